bus_ctl: RTL

BUS_CTL -- requirements
Module: bus_ctl

---
 rtl/bus_ctl_pkg.sv | 14 +
 rtl/bus_ctl.sv | 98 +++++++++
 2 files changed

// File: rtl/bus_ctl_pkg.sv
// rtl/bus_ctl_pkg.sv - shared state encoding and default timing constants for bus_ctl
package bus_ctl_pkg;

    typedef enum logic [1:0] {
        ST_LATCH  = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int          DEF_WAIT     = 1;
    localparam logic [19:0] DEF_ROM_BASE = 20'hF0000;

endpackage

// File: rtl/bus_ctl.sv
// rtl/bus_ctl.sv - core-to-memory bus cycle sequencer with wait states, ROM write protect and bus hold
module bus_ctl
    import bus_ctl_pkg::*;
#(
    parameter int          WAIT     = DEF_WAIT,
    parameter logic [19:0] ROM_BASE = DEF_ROM_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  core_out,
    input  logic        core_we,
    output logic [7:0]  core_in,
    output logic        ce,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_oe,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic        hold_req,
    output logic        hold_ack
);

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        wr_q, wr_d;
    logic [7:0]  core_in_q, core_in_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_LATCH;
            cnt_q      <= 4'd0;
            mem_addr_q <= 20'd0;
            mem_dout_q <= 8'd0;
            wr_q       <= 1'b0;
            core_in_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            wr_q       <= wr_d;
            core_in_q  <= core_in_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        wr_d       = wr_q;
        core_in_d  = core_in_q;
        ce         = 1'b0;
        mem_oe     = 1'b0;
        mem_we     = 1'b0;
        hold_ack   = 1'b0;
        unique case (state_q)
            ST_LATCH: begin
                mem_addr_d = address;
                mem_dout_d = core_out;
                wr_d       = core_we;
                cnt_d      = 4'd0;
                state_d    = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_oe = !wr_q;
                // Writes into ROM space run full timing but never strobe the memory
                mem_we = wr_q && (mem_addr_q < ROM_BASE);
                if (cnt_q < WAIT_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (mem_ready) begin
                    state_d = ST_DONE;
                    if (!wr_q) core_in_d = mem_din;
                end
            end
            ST_DONE: begin
                ce      = 1'b1;
                state_d = hold_req ? ST_HOLD : ST_LATCH;
            end
            ST_HOLD: begin
                hold_ack = 1'b1;
                if (!hold_req) state_d = ST_LATCH;
            end
            default: state_d = ST_LATCH;
        endcase
    end

    assign core_in  = core_in_q;
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;

endmodule
